// File: rtl/seq_and_join_ctrl.sv
// Two-thread "and" join sequencer: thread 1 (a ##1 b ##1 c) and thread 2 (d ##1 e==data) meet in a CHECK cycle.
// Optional macro JOIN_TIMEOUT_EN bounds how long a finished thread waits for its partner.
//
// state   | meaning
// T1_IDLE | thread 1 waiting for a
// T1_B    | thread 1 expects b, captures x1/y
// T1_C    | thread 1 expects c
// T1_DONE | thread 1 finished, waiting for join
// T2_IDLE | thread 2 waiting for d
// T2_CAP  | thread 2 captures x2, expects e==data
// T2_DONE | thread 2 finished, waiting for join
// both DONE is the CHECK cycle
module seq_and_join_ctrl #(
  parameter int DW      = 32,
  parameter int X_OWNER = 1,
  parameter int CHECK_X = 0,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  input  logic          c,
  input  logic          d,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  input  logic [DW-1:0] e,
  output logic          busy,
  output logic          match,
  output logic          fail,
  output logic [2:0]    fail_code,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [15:0]   match_cnt
);

  typedef enum logic [1:0] {T1_IDLE, T1_B, T1_C, T1_DONE} t1_state_t;
  typedef enum logic [1:0] {T2_IDLE, T2_CAP, T2_DONE} t2_state_t;

  t1_state_t t1_q, t1_d;
  t2_state_t t2_q, t2_d;
  logic [2:0] code1, code2, code_d;
  logic       match_d, fail_d;
  logic       both_done, one_done, cmp_ok, tmo_hit;
  logic       cap1, cap2;

  assign both_done = (t1_q == T1_DONE) && (t2_q == T2_DONE);
  assign one_done  = (t1_q == T1_DONE) ^ (t2_q == T2_DONE);
  // only the owner's x is ever published, so x_out doubles as the owner x for the compare
  assign cmp_ok    = (CHECK_X != 0) ? (data2 == x_out) : (data2 == y_out);
  assign cap1      = (t1_q == T1_B) && b;
  assign cap2      = (t2_q == T2_CAP);
  assign busy      = (t1_q != T1_IDLE) || (t2_q != T2_IDLE);
  assign fail_d    = (code_d != 3'd0);

`ifdef JOIN_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt;

  // reloads whenever nobody is waiting alone, so join and abort both clear it
  always_ff @(posedge clk) begin
    if (rst || !one_done || fail_d) tmo_cnt <= TW'(TIMEOUT - 1);
    else if (tmo_cnt != '0)         tmo_cnt <= tmo_cnt - TW'(1);
  end

  assign tmo_hit = one_done && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    t1_d    = t1_q;
    t2_d    = t2_q;
    code1   = 3'd0;
    code2   = 3'd0;
    code_d  = 3'd0;
    match_d = 1'b0;
    case (t1_q)
      T1_IDLE: if (a) t1_d = T1_B;
      T1_B:    if (b) t1_d = T1_C;    else code1 = 3'd1;
      T1_C:    if (c) t1_d = T1_DONE; else code1 = 3'd2;
      default: ;
    endcase
    case (t2_q)
      T2_IDLE: if (d) t2_d = T2_CAP;
      T2_CAP:  if (e == data) t2_d = T2_DONE; else code2 = 3'd3;
      default: ;
    endcase
    if (code1 != 3'd0)              code_d = code1;
    else if (code2 != 3'd0)         code_d = code2;
    else if (both_done && !cmp_ok)  code_d = 3'd4;
    else if (tmo_hit)               code_d = 3'd5;
    match_d = both_done && cmp_ok;
    if (both_done || (code_d != 3'd0)) begin
      t1_d = T1_IDLE;
      t2_d = T2_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t1_q      <= T1_IDLE;
      t2_q      <= T2_IDLE;
      match     <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 3'd0;
      x_out     <= '0;
      y_out     <= '0;
      match_cnt <= 16'd0;
    end else begin
      t1_q      <= t1_d;
      t2_q      <= t2_d;
      match     <= match_d;
      fail      <= fail_d;
      fail_code <= code_d;
      if (match_d && (match_cnt != 16'hFFFF)) match_cnt <= match_cnt + 16'd1;
      if (cap1) begin
        y_out <= data1;
        if (X_OWNER == 1) x_out <= data;
      end
      if (cap2 && (X_OWNER == 2)) x_out <= data;
    end
  end

endmodule
